// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// bsg_manycore_eva_to_npa_pipe: handshaked EVA->NPA translator with programmable tile-group origin, DMEM-overflow window and output buffer
//   clk_i/reset_i          : clock, synchronous active-high reset
//   pod_x_i/pod_y_i        : own pod coordinates (quasi-static)
//   cfg_*                  : config write (tile-group origin, overflow window [lo,hi] inclusive)
//   v_i/eva_i/tag_i/ready_o: request side, accept on v_i & ready_o
//   v_o/yumi_i + data      : result side, consumer takes head with yumi_i
//   invalid_cnt_o          : saturating count of accepted invalid EVAs
//   Optional macro BSG_MANYCORE_EVA_NPA_TRACE_EN: trace of redirected/invalid requests and a yumi_i-implies-v_o check.
//   EVA layouts: global {01, y[29:23], x[22:16], addr[15:2], 2'b0}; tile-group {001, y[28:23], x[22:17], addr[16:2], 2'b0}.
//   DRAM hash assumes num_tiles_x_p*2*num_vcache_rows_p is a power of two: bank = EVA word-block bits,
//   bank = {row, south_not_north, x_subcord}; EPA = {bank index, word-in-block}.
module bsg_manycore_eva_to_npa_pipe #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int pod_x_cord_width_p = 3,
  parameter int pod_y_cord_width_p = 4,
  parameter int num_tiles_x_p = 16,
  parameter int num_tiles_y_p = 8,
  parameter int num_vcache_rows_p = 1,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int dmem_words_p = 1024,
  parameter int els_p = 2,
  localparam int x_sub_lp = $clog2(num_tiles_x_p),
  localparam int y_sub_lp = $clog2(num_tiles_y_p)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  input  logic cfg_v_i,
  input  logic [x_sub_lp-1:0] cfg_tgo_x_i,
  input  logic [y_sub_lp-1:0] cfg_tgo_y_i,
  input  logic cfg_ovf_en_i,
  input  logic [15:0] cfg_ovf_lo_i,
  input  logic [15:0] cfg_ovf_hi_i,
  input  logic v_i,
  input  logic [data_width_p-1:0] eva_i,
  input  logic [7:0] tag_i,
  output logic ready_o,
  output logic v_o,
  input  logic yumi_i,
  output logic [x_cord_width_p-1:0] x_cord_o,
  output logic [y_cord_width_p-1:0] y_cord_o,
  output logic [addr_width_p-1:0] epa_o,
  output logic [7:0] tag_o,
  output logic invalid_o,
  output logic ovf_o,
  output logic [15:0] invalid_cnt_o
);
  localparam int lg_blk_lp = $clog2(vcache_block_size_in_words_p);
  localparam int lg_rows_lp = num_vcache_rows_p > 1 ? $clog2(num_vcache_rows_p) : 1;
  localparam int lg_banks_lp = $clog2(num_tiles_x_p*2*num_vcache_rows_p);
  localparam int hin_w_lp = data_width_p-3-lg_blk_lp;
  localparam int entry_w_lp = x_cord_width_p+y_cord_width_p+addr_width_p+10;
  localparam int ptr_w_lp = $clog2(els_p);
  logic [x_sub_lp-1:0] tgo_x;
  logic [y_sub_lp-1:0] tgo_y;
  logic ovf_en;
  logic [15:0] ovf_lo, ovf_hi;
  logic [hin_w_lp-1:0] hin;
  logic [lg_banks_lp-1:0] bank;
  logic [lg_rows_lp-1:0] row;
  logic south;
  logic [y_sub_lp-1:0] dram_y_sub;
  logic [x_cord_width_p-1:0] dram_x, glob_x, tg_x, x_n;
  logic [y_cord_width_p-1:0] dram_y, glob_y, tg_y, y_n;
  logic [addr_width_p-1:0] dram_epa, glob_epa, tg_epa, epa_n;
  logic [14:0] tg_addr;
  logic is_dram, is_glob, is_tg, in_win, ovf_n, inv_n;
  logic accept, deq;
  logic [entry_w_lp-1:0] mem [els_p];
  logic [ptr_w_lp-1:0] wp, rp;
  logic [ptr_w_lp:0] cnt;
  logic unused;
  assign unused = ^{eva_i[1:0], eva_i[28:23+y_sub_lp], eva_i[22:17+x_sub_lp]};
  always_comb begin
    hin = eva_i[2+lg_blk_lp +: hin_w_lp];
    bank = hin[lg_banks_lp-1:0];
    south = bank[x_sub_lp];
    row = lg_rows_lp'(bank >> (x_sub_lp+1)) & lg_rows_lp'(num_vcache_rows_p-1);
    // north rows are counted upward from the bottom edge of the pod above
    dram_y_sub = south ? y_sub_lp'(row) : y_sub_lp'(num_tiles_y_p-1) - y_sub_lp'(row);
    dram_x = {pod_x_i, bank[x_sub_lp-1:0]};
    dram_y = {south ? pod_y_i + pod_y_cord_width_p'(1) : pod_y_i - pod_y_cord_width_p'(1), dram_y_sub};
    dram_epa = addr_width_p'({hin >> lg_banks_lp, eva_i[2 +: lg_blk_lp]});
    glob_x = x_cord_width_p'(eva_i[22:16]);
    glob_y = y_cord_width_p'(eva_i[29:23]);
    glob_epa = addr_width_p'(eva_i[15:2]);
    tg_addr = eva_i[16:2];
    tg_x = {pod_x_i, eva_i[17 +: x_sub_lp] + tgo_x};
    tg_y = {pod_y_i, eva_i[23 +: y_sub_lp] + tgo_y};
    tg_epa = addr_width_p'(tg_addr & 15'(dmem_words_p-1));
    in_win = ovf_en & ({1'b0, tg_addr} >= ovf_lo) & ({1'b0, tg_addr} <= ovf_hi);
    is_dram = eva_i[31];
    is_glob = eva_i[31:30] == 2'b01;
    is_tg = eva_i[31:29] == 3'b001;
    ovf_n = is_tg & in_win;
    inv_n = ~(is_dram | is_glob | is_tg);
    x_n = (is_dram | ovf_n) ? dram_x : is_glob ? glob_x : is_tg ? tg_x : '0;
    y_n = (is_dram | ovf_n) ? dram_y : is_glob ? glob_y : is_tg ? tg_y : '0;
    epa_n = (is_dram | ovf_n) ? dram_epa : is_glob ? glob_epa : is_tg ? tg_epa : '0;
  end
  assign ready_o = cnt != (ptr_w_lp+1)'(els_p);
  assign v_o = cnt != '0;
  assign accept = v_i & ready_o;
  assign deq = yumi_i & v_o;
  assign {x_cord_o, y_cord_o, epa_o, tag_o, invalid_o, ovf_o} = mem[rp];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tgo_x <= '0;
      tgo_y <= '0;
      ovf_en <= 1'b0;
      ovf_lo <= '0;
      ovf_hi <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      invalid_cnt_o <= '0;
    end else begin
      if (cfg_v_i) begin
        tgo_x <= cfg_tgo_x_i;
        tgo_y <= cfg_tgo_y_i;
        ovf_en <= cfg_ovf_en_i;
        ovf_lo <= cfg_ovf_lo_i;
        ovf_hi <= cfg_ovf_hi_i;
      end
      if (accept) wp <= wp == ptr_w_lp'(els_p-1) ? '0 : wp + ptr_w_lp'(1);
      if (deq) rp <= rp == ptr_w_lp'(els_p-1) ? '0 : rp + ptr_w_lp'(1);
      cnt <= cnt + (ptr_w_lp+1)'(accept) - (ptr_w_lp+1)'(deq);
      if (accept & inv_n & (invalid_cnt_o != 16'hFFFF)) invalid_cnt_o <= invalid_cnt_o + 16'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) mem[wp] <= {x_n, y_n, epa_n, tag_i, inv_n, ovf_n};
  end
`ifdef BSG_MANYCORE_EVA_NPA_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept && (ovf_n || inv_n))
      $display("%t eva_to_npa: eva=%h tag=%h x=%h y=%h epa=%h inv=%b ovf=%b", $time, eva_i, tag_i, x_n, y_n, epa_n, inv_n, ovf_n);
    if (!reset_i) assert (!yumi_i || v_o) else $error("eva_to_npa: yumi_i asserted while v_o is low");
  end
`endif
endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// tb_bsg_manycore_eva_to_npa_pipe: directed scoreboard bench for the EVA->NPA pipe
module tb_bsg_manycore_eva_to_npa_pipe;
  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic [27:0] epa;
    logic [7:0] tag;
    logic inv;
    logic ovf;
  } exp_t;
  logic clk = 0, reset = 1;
  logic [2:0] pod_x = 3'd1;
  logic [3:0] pod_y = 4'd1;
  logic cfg_v = 0, cfg_ovf_en = 0;
  logic [3:0] cfg_tgo_x = 0;
  logic [2:0] cfg_tgo_y = 0;
  logic [15:0] cfg_ovf_lo = 0, cfg_ovf_hi = 0;
  logic v_i = 0, yumi_en = 0, yumi;
  logic [31:0] eva = 0;
  logic [7:0] tag_i = 0;
  logic ready, v_o, invalid, ovf;
  logic [6:0] x_cord, y_cord;
  logic [27:0] epa;
  logic [7:0] tag_o;
  logic [15:0] invalid_cnt;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  assign yumi = yumi_en & v_o;
  always #5 clk = ~clk;
  bsg_manycore_eva_to_npa_pipe dut (
    .clk_i(clk), .reset_i(reset), .pod_x_i(pod_x), .pod_y_i(pod_y),
    .cfg_v_i(cfg_v), .cfg_tgo_x_i(cfg_tgo_x), .cfg_tgo_y_i(cfg_tgo_y),
    .cfg_ovf_en_i(cfg_ovf_en), .cfg_ovf_lo_i(cfg_ovf_lo), .cfg_ovf_hi_i(cfg_ovf_hi),
    .v_i(v_i), .eva_i(eva), .tag_i(tag_i), .ready_o(ready),
    .v_o(v_o), .yumi_i(yumi), .x_cord_o(x_cord), .y_cord_o(y_cord), .epa_o(epa),
    .tag_o(tag_o), .invalid_o(invalid), .ovf_o(ovf), .invalid_cnt_o(invalid_cnt));
  always @(negedge clk) begin
    if (!reset && v_o && yumi_en) begin
      exp_t e, a;
      a = '{x_cord, y_cord, epa, tag_o, invalid, ovf};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got x=%h y=%h epa=%h tag=%h inv=%b ovf=%b with nothing expected", a.x, a.y, a.epa, a.tag, a.inv, a.ovf);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL output_tag%0h: got x=%h y=%h epa=%h tag=%h inv=%b ovf=%b, want x=%h y=%h epa=%h tag=%h inv=%b ovf=%b",
                   e.tag, a.x, a.y, a.epa, a.tag, a.inv, a.ovf, e.x, e.y, e.epa, e.tag, e.inv, e.ovf);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  int last_waits;
  task automatic send(input logic [31:0] e, input logic [7:0] t, input logic [6:0] x, input logic [6:0] y,
                      input logic [27:0] p, input logic inv, input logic o);
    logic r;
    last_waits = 0;
    v_i = 1; eva = e; tag_i = t;
    forever begin
      r = ready;
      @(posedge clk); #1;
      if (r) begin
        q.push_back('{x, y, p, t, inv, o});
        break;
      end
      last_waits++;
      if (last_waits > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout tag%0h: ready_o stayed 0 for %0d cycles, want accept", t, last_waits);
        break;
      end
    end
    v_i = 0;
  endtask
  task automatic cfg(input logic [3:0] tx, input logic [2:0] ty, input logic en, input logic [15:0] lo, input logic [15:0] hi);
    cfg_v = 1; cfg_tgo_x = tx; cfg_tgo_y = ty; cfg_ovf_en = en; cfg_ovf_lo = lo; cfg_ovf_hi = hi;
    @(posedge clk); #1;
    cfg_v = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask
  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_ready", ready, 1);
    chk("reset_v", v_o, 0);
    chk("reset_cnt", invalid_cnt, 0);
    cfg(4'd3, 3'd2, 0, 0, 0);
    yumi_en = 1;
    send(32'h2084_0040, 8'h01, 7'h15, 7'h0B, 28'h10, 0, 0);
    chk("latency_v", v_o, 1);
    send(32'h8000_0064, 8'h02, 7'h13, 7'h07, 28'h1, 0, 0);
    send(32'h8000_06B4, 8'h03, 7'h15, 7'h10, 28'hD, 0, 0);
    cfg(4'd3, 3'd2, 1, 16'h100, 16'h4FF);
    send(32'h2084_0800, 8'h04, 7'h10, 7'h07, 28'h410810, 0, 1);
    send(32'h2084_1400, 8'h05, 7'h15, 7'h0B, 28'h100, 0, 0);
    cfg(4'd3, 3'd2, 1, 16'h300, 16'h100);
    send(32'h2084_0800, 8'h06, 7'h15, 7'h0B, 28'h200, 0, 0);
    cfg(4'd3, 3'd2, 1, 16'h200, 16'h200);
    send(32'h2084_0800, 8'h07, 7'h10, 7'h07, 28'h410810, 0, 1);
    cfg(4'd3, 3'd2, 0, 0, 0);
    w = 0;
    for (int i = 0; i < 4; i++) begin
      send(32'h4103_0080 + 32'(4*i), 8'h10 + 8'(i), 7'h03, 7'h02, 28'h20 + 28'(i), 0, 0);
      w += last_waits;
    end
    chk("throughput_waits", w, 0);
    drain();
    yumi_en = 0;
    for (int i = 0; i < 2; i++) send(32'h4103_0100 + 32'(4*i), 8'(i), 7'h03, 7'h02, 28'h40 + 28'(i), 0, 0);
    chk("full_ready", ready, 0);
    chk("full_v", v_o, 1);
    yumi_en = 1;
    for (int i = 2; i < 5; i++) send(32'h4103_0100 + 32'(4*i), 8'(i), 7'h03, 7'h02, 28'h40 + 28'(i), 0, 0);
    drain();
    repeat (2) @(posedge clk);
    #1 chk("no_dup_v", v_o, 0);
    cfg_v = 1; cfg_tgo_x = 4'd0; cfg_tgo_y = 3'd2; cfg_ovf_en = 0; cfg_ovf_lo = 0; cfg_ovf_hi = 0;
    send(32'h2084_0040, 8'h20, 7'h15, 7'h0B, 28'h10, 0, 0);
    cfg_v = 0;
    send(32'h2084_0040, 8'h21, 7'h12, 7'h0B, 28'h10, 0, 0);
    send(32'h0000_1000, 8'h30, 7'h00, 7'h00, 28'h0, 1, 0);
    chk("invalid_cnt_1", invalid_cnt, 1);
    for (int i = 0; i < 16'hFFFE; i++) send(32'h0000_1000, 8'(i), 7'h00, 7'h00, 28'h0, 1, 0);
    chk("invalid_cnt_full", invalid_cnt, 16'hFFFF);
    send(32'h1FFF_FFFC, 8'h31, 7'h00, 7'h00, 28'h0, 1, 0);
    chk("invalid_cnt_sat", invalid_cnt, 16'hFFFF);
    drain();
    yumi_en = 0;
    send(32'h4103_0080, 8'h40, 7'h03, 7'h02, 28'h20, 0, 0);
    send(32'h4103_0084, 8'h41, 7'h03, 7'h02, 28'h21, 0, 0);
    reset = 1;
    q.delete();
    @(posedge clk); #1;
    reset = 0;
    chk("rst_v_0", v_o, 0);
    chk("rst_ready_0", ready, 1);
    @(posedge clk); #1;
    chk("rst_v_1", v_o, 0);
    chk("rst_ready_1", ready, 1);
    chk("rst_cnt", invalid_cnt, 0);
    yumi_en = 1;
    send(32'h2084_0040, 8'h50, 7'h12, 7'h09, 28'h10, 0, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_eva_to_npa_pipe.md
Name: bsg_manycore_eva_to_npa_pipe

Overview:
- Pipelined, handshaked EVA->NPA translator for manycore endpoints (vanilla core remote path, accelerators).
- Maps DRAM, global and tile-group EVAs onto (x_cord, y_cord, EPA).
- Programmable tile-group origin and a programmable DMEM-overflow window: tile-group accesses inside the window are redirected to DRAM.
- Sits between the endpoint's request generator and its network-link packet builder; includes a small output buffer so the network side can backpressure.

Parameters:
- data_width_p, 32, EVA width in bits.
- addr_width_p, 28, EPA width (word address).
- x_cord_width_p, 7, global x coordinate width.
- y_cord_width_p, 7, global y coordinate width.
- pod_x_cord_width_p, 3, pod x width.
- pod_y_cord_width_p, 4, pod y width.
- num_tiles_x_p, 16, tiles per pod in x; x_subcord width = clog2.
- num_tiles_y_p, 8, tiles per pod in y; y_subcord width = clog2.
- num_vcache_rows_p, 1, vcache rows per pod side, passed to the DRAM hash.
- vcache_block_size_in_words_p, 8, vcache line size, passed to the DRAM hash.
- dmem_words_p, 1024, local DMEM depth; tile-group EPA is masked to clog2(dmem_words_p) bits.
- els_p, 2, output buffer depth; must be >= 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- pod_x_i  in  pod_x_cord_width_p  own pod x; quasi-static.
- pod_y_i  in  pod_y_cord_width_p  own pod y; quasi-static.
- cfg_v_i  in  1  config write strobe.
- cfg_tgo_x_i  in  x_subcord  new tile-group origin x.
- cfg_tgo_y_i  in  y_subcord  new tile-group origin y.
- cfg_ovf_en_i  in  1  overflow window enable.
- cfg_ovf_lo_i  in  16  window low bound, inclusive, word address.
- cfg_ovf_hi_i  in  16  window high bound, inclusive.
- v_i  in  1  request valid.
- eva_i  in  data_width_p  byte EVA.
- tag_i  in  8  opaque request tag.
- ready_o  out  1  request can be accepted.
- v_o  out  1  translation valid.
- yumi_i  in  1  consumer takes the head entry; legal only when v_o = 1.
- x_cord_o  out  x_cord_width_p  destination x.
- y_cord_o  out  y_cord_width_p  destination y.
- epa_o  out  addr_width_p  endpoint physical word address.
- tag_o  out  8  tag returned with the translation.
- invalid_o  out  1  EVA maps to no NPA.
- ovf_o  out  1  request was redirected to DRAM by the overflow window.
- invalid_cnt_o  out  16  saturating count of invalid translations.

Behaviour:
- Reset: ready_o = 1, v_o = 0, buffer empty, tgo = (0,0), ovf_en = 0, lo = 0, hi = 0, invalid_cnt_o = 0. Data outputs are don't-care while v_o = 0; the bench must not check them.
- Accept occurs when v_i & ready_o. ready_o = buffer not full; it is a registered/count-derived flag with no combinational dependence on v_i.
- Latency: the translation is presented at v_o in the cycle after accept when the buffer was empty. Output order matches accept order.
- Throughput: one accept per cycle sustained while yumi_i is held high.
- Full buffer: accept and yumi in the same cycle is legal.
- Classification (bsg_manycore_pkg struct layout):
  - eva[31] = 1: DRAM; use bsg_manycore_dram_hash_function.
  - else eva[31:30] = 01: global; x, y and EPA taken directly from the fields, EPA zero-extended.
  - else eva[31:29] = 001: tile-group.
  - else: invalid; x = y = epa = 0, invalid_o = 1.
- Tile-group mapping:
  - x = {pod_x_i, (x_field + tgo_x) mod 2^x_subcord}; y likewise.
  - EPA = addr_field & (dmem_words_p - 1). Wrap of the sum is silent.
- Overflow redirect: if ovf_en & lo <= addr_field <= hi, translate instead as DRAM EVA {1'b1, eva[30:0]} and set ovf_o = 1. lo > hi means an empty window.
- Config timing: a config write in cycle t affects requests accepted in cycle t+1 onward. A request accepted in the same cycle t uses the old values. Entries already in the buffer are unaffected.
- Counter: invalid_cnt_o increments on accept of an invalid EVA and saturates at 0xFFFF.
- Reset mid-operation: buffered entries are discarded; no v_o in the cycle after reset deasserts.

Optional Feature:
- Macro BSG_MANYCORE_EVA_NPA_TRACE_EN.
- Defined: on each accepted request with ovf_o = 1 or invalid_o = 1, $display time, eva, tag and result. Also asserts yumi_i implies v_o and errors on violation.
- Undefined: no display, no assertions; RTL is functionally identical.

Test Plan:
- Setup for tile-group cases: pod = (1,1), cfg tgo = (3,2).
- Tile-group: EVA with x = 2, y = 1, addr = 0x010 -> next cycle v_o, x_cord = {1,5}, y_cord = {1,3}, epa = 0x010, ovf_o = 0.
- Overflow: cfg ovf_en = 1, lo = 0x100, hi = 0x4FF; tile-group addr = 0x200 -> ovf_o = 1; x/y/epa equal the DRAM hash of {1, eva[30:0]}. addr = 0x500 -> ovf_o = 0, epa = 0x100.
- Backpressure: stream 5 global EVAs with yumi_i = 0 -> ready_o drops after 2 accepts. Then raise yumi_i -> outputs in order with tags 0..4, no loss or duplication.
- Config race: cfg_v_i (tgo x = 0) and accept of a tile-group EVA (x = 2) in the same cycle -> x subcoord = 5. A request the next cycle -> x subcoord = 2.
- Invalid: EVA 0x0000_1000 -> invalid_o = 1, x = y = epa = 0, invalid_cnt_o = 1. Preload 0xFFFF worth of invalids, then one more -> stays 0xFFFF.
- Reset with 2 entries buffered -> v_o = 0 and ready_o = 1 in the cycle after reset deasserts.
